// File: rtl/aes_decrypt_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_iter_pkg
// Purpose  : Shared AES inverse-cipher definitions: mode encoding, round
//            counts, GF(2^8) arithmetic, inverse S-box, InvShiftRows.
// Revision : 1.0 - initial release
// ============================================================================
package aes_decrypt_iter_pkg;

    typedef enum logic [1:0] {
        AES_128     = 2'd0,
        AES_192     = 2'd1,
        AES_256     = 2'd2,
        AES_256_ALT = 2'd3
    } aes_mode_e;

    localparam int c_nr_128 = 10;
    localparam int c_nr_192 = 12;
    localparam int c_nr_256 = 14;
    localparam int c_rnd_w  = 4;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply over bits 1..7);
    // maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte n = row (n%4), column (n/4); row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    // Round count for a mode, clamped to what the build supports.
    function automatic logic [c_rnd_w-1:0] mode_nr(input logic [1:0] mode, input int max_rounds);
        int nr;
        case (aes_mode_e'(mode))
            AES_128: nr = c_nr_128;
            AES_192: nr = c_nr_192;
            default: nr = c_nr_256;
        endcase
        if (nr > max_rounds) nr = max_rounds;
        return c_rnd_w'(nr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_decrypt_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_iter_if
// Purpose  : Block handshake bundle for the iterative AES decrypt core.
//            Input side valid/ready (v_i, ready_o, mode_i, data_i,
//            key_chain_i); output side valid/yumi (v_o, data_o, yumi_i).
//            Signal suffixes are from the core's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_decrypt_iter_if #(
    parameter int MAX_ROUNDS_P = 14
);
    localparam int KEY_CHAIN_W = 128 * (MAX_ROUNDS_P + 1);

    logic                   v_i;
    logic                   ready_o;
    logic [1:0]             mode_i;
    logic [127:0]           data_i;
    logic [KEY_CHAIN_W-1:0] key_chain_i;
    logic                   v_o;
    logic [127:0]           data_o;
    logic                   yumi_i;

    modport master (
        output v_i, mode_i, data_i, key_chain_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, mode_i, data_i, key_chain_i, yumi_i,
        output ready_o, v_o, data_o
    );
endinterface
`default_nettype wire

// File: rtl/aes_decrypt_iter_inv_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_iter_inv_round
// Purpose  : Combinational AES inverse round:
//            InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
//            with InvMixColumns bypassed on the last round.
// Ports    : i_state, i_round_key, i_last_round -> o_state
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_iter_inv_round
    import aes_decrypt_iter_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_last_round,
    output logic [127:0] o_state
);
    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    assign w_isr = inv_shift_rows(i_state);

    for (genvar n = 0; n < 16; n++) begin : g_byte
        assign w_isb[127-8*n -: 8] = inv_sbox(w_isr[127-8*n -: 8]);
    end

    assign w_ark = w_isb ^ i_round_key;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_ark[127-32*c -: 8];
        assign w_a1 = w_ark[119-32*c -: 8];
        assign w_a2 = w_ark[111-32*c -: 8];
        assign w_a3 = w_ark[103-32*c -: 8];
        assign w_imc[127-32*c -: 32] = {
            gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09),
            gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d),
            gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b),
            gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e)
        };
    end

    assign o_state = i_last_round ? w_ark : w_imc;

endmodule
`default_nettype wire

// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_iter
// Purpose  : Iterative AES-128/192/256 inverse cipher, one round per clock.
//            Accept in cycle A, plaintext valid from cycle A+Nr+1 until the
//            consumer asserts yumi_i.
// Ports    : clk_i, reset_i (synchronous, active high),
//            bus (aes_decrypt_iter_if.slave): v_i/ready_o/mode_i/data_i/
//            key_chain_i in, v_o/data_o/yumi_i out.
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_iter
    import aes_decrypt_iter_pkg::*;
#(
    parameter int MAX_ROUNDS_P = 14,
    parameter int KEY_LATCH_P  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    aes_decrypt_iter_if.slave  bus
);
    localparam int KEY_CHAIN_W = 128 * (MAX_ROUNDS_P + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]             r_fsm, w_fsm_nxt;
    logic [c_rnd_w-1:0]     r_rnd, w_rnd_nxt;
    logic [127:0]           r_state, w_state_nxt;
    logic [c_rnd_w-1:0]     w_nr_in;
    logic                   w_accept;
    logic                   w_v_o;
    logic [KEY_CHAIN_W-1:0] w_key_src;
    logic [127:0]           w_rk_in  [0:MAX_ROUNDS_P];
    logic [127:0]           w_rk_src [0:MAX_ROUNDS_P];
    logic [127:0]           w_round_out;

    assign w_accept = (r_fsm == c_st_idle) && bus.v_i;
    assign w_nr_in  = mode_nr(bus.mode_i, MAX_ROUNDS_P);

    // Key chain source for the running block. Without the latch the caller
    // must hold key_chain_i until the result is taken.
    if (KEY_LATCH_P != 0) begin : g_key_latch
        logic [KEY_CHAIN_W-1:0] r_key;
        // Only ever read after an accept has loaded it, so no reset needed.
        always_ff @(posedge clk_i) begin
            if (w_accept) r_key <= bus.key_chain_i;
        end
        assign w_key_src = r_key;
    end else begin : g_key_direct
        assign w_key_src = bus.key_chain_i;
    end

    // Round key k sits at the top of the chain for k=0; layout always
    // follows the build's maximum round count.
    for (genvar k = 0; k <= MAX_ROUNDS_P; k++) begin : g_rk
        assign w_rk_in[k]  = bus.key_chain_i[KEY_CHAIN_W-1-128*k -: 128];
        assign w_rk_src[k] = w_key_src[KEY_CHAIN_W-1-128*k -: 128];
    end

    aes_decrypt_iter_inv_round u_round (
        .i_state      (r_state),
        .i_round_key  (w_rk_src[r_rnd]),
        .i_last_round (r_rnd == '0),
        .o_state      (w_round_out)
    );

    // The round counter alone tracks progress, so Nr/mode need no
    // separate storage beyond the accept edge.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_rnd_nxt   = r_rnd;
        w_state_nxt = r_state;
        case (r_fsm)
            c_st_idle: begin
                if (bus.v_i) begin
                    w_state_nxt = bus.data_i ^ w_rk_in[w_nr_in];
                    w_rnd_nxt   = w_nr_in - c_rnd_w'(1);
                    w_fsm_nxt   = c_st_run;
                end
            end
            c_st_run: begin
                w_state_nxt = w_round_out;
                if (r_rnd == '0) w_fsm_nxt = c_st_done;
                else             w_rnd_nxt = r_rnd - c_rnd_w'(1);
            end
            c_st_done: begin
                if (bus.yumi_i) w_fsm_nxt = c_st_idle;
            end
            default: w_fsm_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fsm   <= c_st_idle;
            r_rnd   <= '0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_rnd   <= w_rnd_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign w_v_o       = (r_fsm == c_st_done);
    assign bus.ready_o = (r_fsm == c_st_idle);
    assign bus.v_o     = w_v_o;
    // Intermediate round states never reach the output.
    assign bus.data_o  = w_v_o ? r_state : 128'h0;

    // yumi_i is only legal while a result is presented.
    always_ff @(posedge clk_i) begin
        if (!reset_i) assert (!(bus.yumi_i && !w_v_o));
    end

endmodule
`default_nettype wire
